// File: rtl/bank_request_router.sv
// Banked scratchpad front end: decodes global addresses per interleave mode,
// arbitrates each bank round-robin, registers bank commands, returns reads at T+2.
module bank_request_router #(
  parameter int ADDR_W = 10,
  parameter int NB     = 4,
  parameter int NREQ   = 2,
  parameter int DATA_W = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             mode,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ*ADDR_W-1:0]           req_addr,
  input  logic [NREQ-1:0]                  req_we,
  input  logic [NREQ*DATA_W-1:0]           req_wdata,
  output logic [NREQ-1:0]                  rsp_valid,
  output logic [NREQ*DATA_W-1:0]           rsp_rdata,
  output logic [NB-1:0]                    bank_en,
  output logic [NB-1:0]                    bank_we,
  output logic [NB*(ADDR_W-$clog2(NB))-1:0] bank_addr,
  output logic [NB*DATA_W-1:0]             bank_wdata,
  input  logic [NB*DATA_W-1:0]             bank_rdata,
  output logic [15:0]                      stall_count
);
  localparam int BANK_BITS = $clog2(NB);
  localparam int LOCAL_W   = ADDR_W - BANK_BITS;
  localparam int ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [BANK_BITS-1:0]    dec_bank  [NREQ];
  logic [LOCAL_W-1:0]      dec_local [NREQ];
  logic [NREQ-1:0]         granted;
  logic [NB-1:0]           bank_hit;
  logic [ID_W-1:0]         bank_win  [NB];
  logic                    any_stall;

  logic [ID_W-1:0]         rr_q [NB], rr_d [NB];
  logic [NB-1:0]           bank_en_q, bank_en_d, bank_we_q, bank_we_d;
  logic [NB*LOCAL_W-1:0]   bank_addr_q, bank_addr_d;
  logic [NB*DATA_W-1:0]    bank_wdata_q, bank_wdata_d;
  logic [NB-1:0]           rd_pend_q, rd_pend_d, tag_v_q, tag_v_d;
  logic [ID_W-1:0]         rd_id_q [NB], rd_id_d [NB];
  logic [ID_W-1:0]         tag_id_q [NB], tag_id_d [NB];
  logic [15:0]             stall_count_q, stall_count_d;

  function automatic logic [ID_W-1:0] rr_pick(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return ID_W'(s % NREQ);
  endfunction

  always_comb begin : decode
    for (int i = 0; i < NREQ; i++) begin
      if (mode) begin
        dec_bank[i]  = req_addr[i*ADDR_W + ADDR_W - 1 -: BANK_BITS];
        dec_local[i] = req_addr[i*ADDR_W +: LOCAL_W];
      end else begin
        dec_bank[i]  = req_addr[i*ADDR_W +: BANK_BITS];
        dec_local[i] = req_addr[i*ADDR_W + BANK_BITS +: LOCAL_W];
      end
    end
  end

  // First valid requester at or after rr[b] (cyclic) that targets bank b wins it.
  always_comb begin : arbitrate
    granted  = '0;
    bank_hit = '0;
    for (int b = 0; b < NB; b++) begin
      bank_win[b] = '0;
      for (int k = 0; k < NREQ; k++) begin
        if (!bank_hit[b] && req_valid[rr_pick(rr_q[b], k)] &&
            dec_bank[rr_pick(rr_q[b], k)] == BANK_BITS'(b)) begin
          bank_hit[b] = 1'b1;
          bank_win[b] = rr_pick(rr_q[b], k);
          granted[rr_pick(rr_q[b], k)] = 1'b1;
        end
      end
    end
  end

  // Handshake: a request is accepted in the cycle where req_valid[i] and
  // req_ready[i] are both high; ready never rises without valid, and a
  // requester that is not accepted keeps its request stable until it is.
  assign req_ready = req_valid & granted & {NREQ{rst_n}};
  assign any_stall = |(req_valid & ~req_ready);

  always_comb begin : next_state
    bank_en_d     = '0;
    bank_we_d     = '0;
    bank_addr_d   = bank_addr_q;
    bank_wdata_d  = bank_wdata_q;
    rd_pend_d     = '0;
    tag_v_d       = rd_pend_q;
    for (int b = 0; b < NB; b++) begin
      rr_d[b]     = rr_q[b];
      rd_id_d[b]  = rd_id_q[b];
      tag_id_d[b] = rd_id_q[b];
      if (bank_hit[b]) begin
        bank_en_d[b] = 1'b1;
        bank_we_d[b] = req_we[bank_win[b]];
        bank_addr_d[b*LOCAL_W +: LOCAL_W]  = dec_local[bank_win[b]];
        bank_wdata_d[b*DATA_W +: DATA_W]   = req_wdata[bank_win[b]*DATA_W +: DATA_W];
        rd_pend_d[b] = !req_we[bank_win[b]];
        rd_id_d[b]   = bank_win[b];
        rr_d[b]      = rr_pick(bank_win[b], 1);
      end
    end
    stall_count_d = (any_stall && stall_count_q != 16'hFFFF) ? stall_count_q + 16'd1
                                                              : stall_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_en_q     <= '0;
      bank_we_q     <= '0;
      bank_addr_q   <= '0;
      bank_wdata_q  <= '0;
      rd_pend_q     <= '0;
      tag_v_q       <= '0;
      stall_count_q <= '0;
      for (int b = 0; b < NB; b++) begin
        rr_q[b]     <= '0;
        rd_id_q[b]  <= '0;
        tag_id_q[b] <= '0;
      end
    end else begin
      bank_en_q     <= bank_en_d;
      bank_we_q     <= bank_we_d;
      bank_addr_q   <= bank_addr_d;
      bank_wdata_q  <= bank_wdata_d;
      rd_pend_q     <= rd_pend_d;
      tag_v_q       <= tag_v_d;
      stall_count_q <= stall_count_d;
      for (int b = 0; b < NB; b++) begin
        rr_q[b]     <= rr_d[b];
        rd_id_q[b]  <= rd_id_d[b];
        tag_id_q[b] <= tag_id_d[b];
      end
    end
  end

  // Read data arrives from the bank in the cycle the tag reaches the second stage.
  always_comb begin : respond
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (tag_v_q[b] && tag_id_q[b] == ID_W'(i)) begin
          rsp_valid[i] = 1'b1;
          rsp_rdata[i*DATA_W +: DATA_W] = bank_rdata[b*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign bank_en     = bank_en_q;
  assign bank_we     = bank_we_q;
  assign bank_addr   = bank_addr_q;
  assign bank_wdata  = bank_wdata_q;
  assign stall_count = stall_count_q;

endmodule
